// File: rtl/trg_mon_readout.sv
// Trigger monitor readout: scans NUM_WORDS monitor registers and emits one framed burst per start.
// Optional checksum trailer word is built in when TRG_MON_CKSUM_EN is defined.
module trg_mon_readout #(
   parameter int unsigned NUM_WORDS = 38,
   parameter int unsigned RD_LAT    = 1
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        start_in,
   output logic        rd_out,
   output logic [7:0]  rd_addr_out,
   input  logic [15:0] mon_data_in,
   output logic [15:0] frm_data_out,
   output logic        frm_valid_out,
   input  logic        frm_ready_in,
   output logic        frm_sof_out,
   output logic        frm_eof_out,
   output logic        busy_out,
   output logic [7:0]  ovr_cnt_out
);

   localparam logic [7:0]  LastIdx  = 8'(NUM_WORDS - 1);
   localparam logic [1:0]  LastWait = 2'(RD_LAT - 1);
   localparam logic [15:0] SyncWord = 16'hEB90;

`ifdef TRG_MON_CKSUM_EN
   typedef enum logic [2:0] {StIdle, StHdr, StAddr, StWait, StSend, StCksum} state_e;
`else
   typedef enum logic [2:0] {StIdle, StHdr, StAddr, StWait, StSend} state_e;
`endif

   state_e      state_q, state_d;
   logic [7:0]  idx_q;
   logic [1:0]  wcnt_q;
   logic [15:0] hold_q;
   logic [7:0]  ovr_q;
   logic        last_word;
`ifdef TRG_MON_CKSUM_EN
   logic [15:0] sum_q;
`endif

   assign last_word = (idx_q == LastIdx);

   // State and datapath registers
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q <= StIdle;
         idx_q   <= '0;
         wcnt_q  <= '0;
         hold_q  <= '0;
         ovr_q   <= '0;
`ifdef TRG_MON_CKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         // Any start seen outside IDLE is an overrun, including the final-accept cycle
         if (start_in && (state_q != StIdle) && (ovr_q != 8'hFF)) begin
            ovr_q <= ovr_q + 8'd1;
         end
         case (state_q)
            StIdle: begin
               if (start_in) begin
                  idx_q <= '0;
`ifdef TRG_MON_CKSUM_EN
                  sum_q <= '0;
`endif
               end
            end
            StAddr: wcnt_q <= '0;
            StWait: begin
               if (wcnt_q == LastWait) begin
                  hold_q <= mon_data_in;
               end else begin
                  wcnt_q <= wcnt_q + 2'd1;
               end
            end
            StSend: begin
               if (frm_ready_in) begin
`ifdef TRG_MON_CKSUM_EN
                  sum_q <= sum_q + hold_q;
`endif
                  if (!last_word) begin
                     idx_q <= idx_q + 8'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: if (start_in) state_d = StHdr;
         StHdr:  if (frm_ready_in) state_d = StAddr;
         StAddr: state_d = StWait;
         StWait: if (wcnt_q == LastWait) state_d = StSend;
         StSend: begin
            if (frm_ready_in) begin
               if (last_word) begin
`ifdef TRG_MON_CKSUM_EN
                  state_d = StCksum;
`else
                  state_d = StIdle;
`endif
               end else begin
                  state_d = StAddr;
               end
            end
         end
`ifdef TRG_MON_CKSUM_EN
         StCksum: if (frm_ready_in) state_d = StIdle;
`endif
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      rd_out        = 1'b0;
      frm_data_out  = '0;
      frm_valid_out = 1'b0;
      frm_sof_out   = 1'b0;
      frm_eof_out   = 1'b0;
      case (state_q)
         StHdr: begin
            frm_data_out  = SyncWord;
            frm_valid_out = 1'b1;
            frm_sof_out   = 1'b1;
         end
         StAddr, StWait: rd_out = 1'b1;
         StSend: begin
            rd_out        = 1'b1;
            frm_data_out  = hold_q;
            frm_valid_out = 1'b1;
`ifndef TRG_MON_CKSUM_EN
            frm_eof_out   = last_word;
`endif
         end
`ifdef TRG_MON_CKSUM_EN
         StCksum: begin
            frm_data_out  = sum_q;
            frm_valid_out = 1'b1;
            frm_eof_out   = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign rd_addr_out = idx_q;
   assign busy_out    = (state_q != StIdle);
   assign ovr_cnt_out = ovr_q;

endmodule

// File: tb/tb_trg_mon_readout.sv
// Directed bench for trg_mon_readout: three instances (38 words / RD_LAT 4 / single word).
// Expectations adapt to TRG_MON_CKSUM_EN when the checksum trailer is built in.
module tb_trg_mon_readout;
`ifdef TRG_MON_CKSUM_EN
   localparam bit CkEn = 1'b1;
`else
   localparam bit CkEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic ready = 1'b1;
   always #5 clk = ~clk;

   logic        rd0, rd1, rd2, v0, v1, v2, sof0, sof1, sof2, eof0, eof1, eof2;
   logic        busy0, busy1, busy2;
   logic [7:0]  addr0, addr1, addr2, ovr0, ovr1, ovr2;
   logic [15:0] mon0, mon1, mon2, d0, d1, d2;
   logic [15:0] p1 [4];
   bit          pat0 = 1'b0;

   trg_mon_readout #(.NUM_WORDS(38), .RD_LAT(1)) u_dut0 (
      .clk_in(clk), .rst_in(rst), .start_in(start), .rd_out(rd0), .rd_addr_out(addr0),
      .mon_data_in(mon0), .frm_data_out(d0), .frm_valid_out(v0), .frm_ready_in(ready),
      .frm_sof_out(sof0), .frm_eof_out(eof0), .busy_out(busy0), .ovr_cnt_out(ovr0));
   trg_mon_readout #(.NUM_WORDS(4), .RD_LAT(4)) u_dut1 (
      .clk_in(clk), .rst_in(rst), .start_in(start), .rd_out(rd1), .rd_addr_out(addr1),
      .mon_data_in(mon1), .frm_data_out(d1), .frm_valid_out(v1), .frm_ready_in(ready),
      .frm_sof_out(sof1), .frm_eof_out(eof1), .busy_out(busy1), .ovr_cnt_out(ovr1));
   trg_mon_readout #(.NUM_WORDS(1), .RD_LAT(1)) u_dut2 (
      .clk_in(clk), .rst_in(rst), .start_in(start), .rd_out(rd2), .rd_addr_out(addr2),
      .mon_data_in(mon2), .frm_data_out(d2), .frm_valid_out(v2), .frm_ready_in(ready),
      .frm_sof_out(sof2), .frm_eof_out(eof2), .busy_out(busy2), .ovr_cnt_out(ovr2));

   // Monitor mux models: one register stage for dut0, four for dut1
   always @(posedge clk) mon0 <= pat0 ? {8'h00, addr0} : 16'h3553;
   always @(posedge clk) begin
      p1[0] <= 16'h1000 + {8'h00, addr1} * 16'h0111;
      p1[1] <= p1[0];
      p1[2] <= p1[1];
      p1[3] <= p1[2];
   end
   assign mon1 = p1[3];
   assign mon2 = 16'hA5C3;

   int          sel = 0;
   logic [15:0] data_s;
   logic        v_s, sof_s, eof_s, busy_s;
   logic [7:0]  addr_s;
   always_comb begin
      data_s = d0; v_s = v0; sof_s = sof0; eof_s = eof0; busy_s = busy0; addr_s = addr0;
      if (sel == 1) begin
         data_s = d1; v_s = v1; sof_s = sof1; eof_s = eof1; busy_s = busy1; addr_s = addr1;
      end else if (sel == 2) begin
         data_s = d2; v_s = v2; sof_s = sof2; eof_s = eof2; busy_s = busy2; addr_s = addr2;
      end
   end

   int n_vec = 0;
   int n_err = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [15:0] wd [64];
   logic [7:0]  wa [64];
   bit          ws [64];
   bit          we [64];
   int          wc [64];
   int          nw, stab_err, neof;
   bit          done;

   // Pulse start, then record every accepted word of the selected instance
   task automatic collect(input int toggle, input int n_ovr, input int abort_at);
      int c;
      bit pv;
      logic [15:0] pd;
      nw = 0; stab_err = 0; neof = 0; pv = 1'b0; pd = '0; done = 1'b0; c = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      while (!done && c < 3000) begin
         ready = (toggle != 0) ? (c % 2 == 1) : 1'b1;
         start = (n_ovr > 0) && (c % 10 == 5) && (c / 10 < n_ovr);
         if (pv && data_s !== pd) stab_err++;
         pv = v_s && !ready;
         pd = data_s;
         if (v_s && ready && nw < 64) begin
            wd[nw] = data_s; wa[nw] = addr_s; ws[nw] = sof_s; we[nw] = eof_s; wc[nw] = c;
            if (eof_s) begin
               neof++;
               done = 1'b1;
            end
            nw++;
            if (abort_at > 0 && nw - 1 == abort_at) done = 1'b1;
         end
         @(negedge clk);
         c++;
      end
      start = 1'b0;
      ready = 1'b1;
      check("frame_done", done, 1);
   endtask

   int nl0, bad, cnt;

   initial begin
      nl0 = 39 + int'(CkEn);
      repeat (3) @(negedge clk);
      check("rst_valid", v0, 0);
      check("rst_busy", busy0, 0);
      check("rst_rd", rd0, 0);
      check("rst_data", d0, 0);
      check("rst_ovr", ovr0, 0);
      rst = 1'b0;

      // All words 3553, ready held high
      collect(0, 0, 0);
      check("t1_len", nw, nl0);
      check("t1_hdr", wd[0], 16'hEB90);
      check("t1_sof", ws[0], 1);
      bad = 0;
      for (int k = 0; k < 38; k++) begin
         if (wd[k+1] !== 16'h3553 || wa[k+1] !== 8'(k) || ws[k+1] || (we[k+1] && k != 37)) bad++;
      end
      check("t1_data", bad, 0);
      check("t1_last", wd[nl0-1], CkEn ? 16'hEA52 : 16'h3553);
      check("t1_eof", we[nl0-1], 1);
      check("t1_idle", busy_s, 0);

      // Address-valued data, ready toggling
      pat0 = 1'b1;
      collect(1, 0, 0);
      check("t2_len", nw, nl0);
      bad = 0;
      for (int k = 0; k < 38; k++) if (wd[k+1] !== 16'(k)) bad++;
      check("t2_data", bad, 0);
      check("t2_stable", stab_err, 0);
      check("t2_last", wd[nl0-1], CkEn ? 16'h02BF : 16'h0025);

      // Three overrun pulses, then confirm no second frame follows
      collect(0, 3, 0);
      check("t3_len", nw, nl0);
      check("t3_ovr", ovr0, 3);
      cnt = 0;
      repeat (100) begin
         @(negedge clk);
         if (v0) cnt++;
      end
      check("t3_one_frame", cnt, 0);

      // Saturation: stall in header, hold start high for 300 cycles
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      check("t3_ovr_clr", ovr0, 0);
      ready = 1'b0; start = 1'b1;
      repeat (301) @(negedge clk);
      start = 1'b0;
      check("t3_ovr_sat", ovr0, 8'hFF);
      ready = 1'b1;
      cnt = 0;
      while (busy0 && cnt < 500) begin
         @(negedge clk);
         cnt++;
      end
      check("t3_drain", busy0, 0);

      // Abort after the 10th data word, then a clean frame
      pat0 = 1'b0;
      collect(0, 0, 10);
      check("t4_words", nw, 11);
      rst = 1'b1;
      @(negedge clk);
      check("t4_valid", v0, 0);
      check("t4_busy", busy0, 0);
      check("t4_eof", eof0, 0);
      check("t4_rd", rd0, 0);
      check("t4_addr", addr0, 0);
      check("t4_data", d0, 0);
      check("t4_noeof", neof, 0);
      rst = 1'b0;
      collect(0, 0, 0);
      check("t4_len", nw, nl0);
      check("t4_hdr", wd[0], 16'hEB90);
      check("t4_last", wd[nl0-1], CkEn ? 16'hEA52 : 16'h3553);

      // RD_LAT=4 instance
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      sel = 1;
      collect(0, 0, 0);
      check("t5_len", nw, 5 + int'(CkEn));
      check("t5_w0", wd[1], 16'h1000);
      check("t5_w1", wd[2], 16'h1111);
      check("t5_w2", wd[3], 16'h1222);
      check("t5_w3", wd[4], 16'h1333);
      bad = 0;
      for (int k = 0; k < 4; k++) if (wc[k+1] - wc[k] != 6) bad++;
      check("t5_gap", bad, 0);
      check("t5_last", wd[4 + int'(CkEn)], CkEn ? 16'h4666 : 16'h1333);

      // Single-word instance
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      sel = 2;
      collect(0, 0, 0);
      check("t6_len", nw, 2 + int'(CkEn));
      check("t6_hdr", wd[0], 16'hEB90);
      check("t6_w0", wd[1], 16'hA5C3);
      check("t6_w0_eof", we[1], !CkEn);
      check("t6_last", wd[1 + int'(CkEn)], 16'hA5C3);
      check("t6_busy", busy_s, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/trg_mon_readout.md
TRG_MON_READOUT -- requirements
Module: trg_mon_readout

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 38: number of monitor addresses scanned (0..NUM_WORDS-1), legal 1..256.
REQ-002 SHALL have parameter RD_LAT, default 1: cycles from rd_addr_out change to valid mon_data_in, legal 1..4.
REQ-003 SHALL have port clk_in  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_in  input  1  synchronous active-high reset.
REQ-005 SHALL have port start_in  input  1  single-cycle request to scan and emit one monitor frame.
REQ-006 SHALL have port rd_out  output  1  read enable to monitor register mux.
REQ-007 SHALL have port rd_addr_out  output  8  monitor register address.
REQ-008 SHALL have port mon_data_in  input  16  monitor mux read data.
REQ-009 SHALL have port frm_data_out  output  16  frame word.
REQ-010 SHALL have port frm_valid_out  output  1  frame word valid.
REQ-011 SHALL have port frm_ready_in  input  1  downstream accepts word when high with frm_valid_out.
REQ-012 SHALL have ports frm_sof_out / frm_eof_out  output  1 each  first / last word markers, qualified by frm_valid_out.
REQ-013 SHALL have port busy_out  output  1  high from frame start until final word accepted.
REQ-014 SHALL have port ovr_cnt_out  output  8  saturating count of start_in pulses ignored while busy.

Function
REQ-015 SHALL implement states IDLE, HDR, ADDR, WAIT, SEND, CKSUM.
REQ-016 IDLE: start_in=1 SHALL move to HDR next cycle, clear running sum and word index to 0.
REQ-017 HDR: SHALL drive frm_data_out=16'hEB90, frm_valid_out=1, frm_sof_out=1; on frm_ready_in=1 move to ADDR.
REQ-018 ADDR: SHALL drive rd_addr_out=index, one cycle, then WAIT; rd_addr_out SHALL stay stable until the word is captured.
REQ-019 WAIT: SHALL count RD_LAT-1 further cycles, then sample mon_data_in into a hold register (capture at end of cycle ADDR+RD_LAT-1... i.e. RD_LAT cycles after ADDR entry) and enter SEND.
REQ-020 SEND: SHALL drive frm_data_out=hold register, frm_valid_out=1; data and markers SHALL remain stable while frm_ready_in=0.
REQ-021 SEND handshake: on frm_ready_in=1, sum SHALL add word modulo 2^16; if index=NUM_WORDS-1 go to CKSUM (or IDLE, see REQ-030), else index+1 and ADDR.
REQ-022 CKSUM: SHALL drive frm_data_out=sum, frm_valid_out=1, frm_eof_out=1; on frm_ready_in=1 return to IDLE.
REQ-023 rd_out SHALL be 1 in ADDR, WAIT, SEND, 0 otherwise.
REQ-024 busy_out SHALL be 1 in every state except IDLE.
REQ-025 start_in in any non-IDLE state SHALL be ignored and increment ovr_cnt_out, saturating at 8'hFF.
REQ-026 start_in on the cycle the final word is accepted SHALL be counted as overrun, not started.
REQ-027 NUM_WORDS=1: frame SHALL be header, one data word, checksum equal to that word.
REQ-028 Frame length SHALL be NUM_WORDS+2 words; no gaps other than backpressure and ADDR/WAIT cycles.

Reset
REQ-029 rst_in=1 SHALL force state IDLE, and next cycle: rd_out=0, rd_addr_out=0, frm_data_out=0, frm_valid_out=0, frm_sof_out=0, frm_eof_out=0, busy_out=0, ovr_cnt_out=0, sum=0; reset mid-frame SHALL abort without emitting frm_eof_out.

Configuration
REQ-030 Macro TRG_MON_CKSUM_EN defined: CKSUM state present as REQ-022. Undefined: CKSUM absent, last data word SHALL carry frm_eof_out=1, frame length NUM_WORDS+1, sum logic removed.

Verification
REQ-031 NUM_WORDS=38, RD_LAT=1, all mon_data_in=16'h3553, frm_ready_in=1, start pulse -> 40 words: EB90 (sof), 38x3553, EA52 (eof); rd_addr_out 0..37 ascending.
REQ-032 mon_data_in=address value, frm_ready_in toggling 1/0 each cycle -> data words 0..37 in order, each held stable while ready low, checksum 16'h02BF.
REQ-033 start_in pulsed 3 times during a frame -> ovr_cnt_out=3, exactly one frame emitted; 300 pulses -> ovr_cnt_out=8'hFF.
REQ-034 rst_in asserted after 10th data word accepted -> all outputs 0 next cycle, no eof; new start_in -> complete correct frame from EB90.
REQ-035 RD_LAT=4, mon_data_in registered 4 cycles after rd_addr_out -> each captured word equals register at its address, 5 cycles ADDR-to-SEND.
REQ-036 TRG_MON_CKSUM_EN undefined, NUM_WORDS=1 -> frame EB90 (sof), one data word (eof), busy_out low one cycle after acceptance.
